// File: rtl/aes_pkg.sv
// Shared AES constants, types, xtime and the forward S-box table.
// Used by the key schedule and by the round datapath.
`default_nettype none

package aes_pkg;

  localparam int AES_NK = 4;
  localparam int AES_NR = 10;
  localparam int AES_NB = 4;

  typedef logic [7:0]  aes_byte_t;
  typedef logic [31:0] aes_word_t;

  function automatic aes_byte_t xtime(input aes_byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  localparam aes_byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

`default_nettype wire

// File: rtl/aes_key_expand_if.sv
// Control and round-key read bus between the key schedule and its consumer.
`default_nettype none

interface aes_key_expand_if;

  logic         start;
  logic [127:0] key_in;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic         busy;
  logic         done;
  logic         keys_valid;

  modport master (
    output start, key_in, rd_idx,
    input  rd_key, busy, done, keys_valid
  );

  modport slave (
    input  start, key_in, rd_idx,
    output rd_key, busy, done, keys_valid
  );

endinterface

`default_nettype wire

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box lookup for one byte.
`default_nettype none

module aes_sbox
  import aes_pkg::*;
(
  input  wire aes_byte_t in_byte,
  output aes_byte_t      out_byte
);

  assign out_byte = SBOX[in_byte];

endmodule

`default_nettype wire

// File: rtl/aes_key_expand.sv
//==============================================================================
// Module  : aes_key_expand
// Brief   : Iterative AES-128 key schedule, one round key per clock into an
//           11-entry buffer read combinationally by index.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
)(
  input  wire                clk,
  input  wire                rst_n,
  aes_key_expand_if.slave    bus
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  state_t       state, state_next;
  logic [3:0]   rnd;
  aes_byte_t    rcon;
  logic [127:0] cur;
  logic [127:0] key_buf [NR+1];
  logic         busy, done, keys_valid;

  logic         load, step, last;
  aes_word_t    rot_w3, sub_w3, temp;
  aes_word_t    n0, n1, n2, n3;

  assign rot_w3 = {cur[23:0], cur[31:24]};

  generate
    for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
        .in_byte  (rot_w3[8*b +: 8]),
        .out_byte (sub_w3[8*b +: 8])
      );
    end
  endgenerate

  // Each new word chains off the one before it, w0 of the new key first.
  assign temp = sub_w3 ^ {rcon, 24'h0};
  assign n0   = cur[127:96] ^ temp;
  assign n1   = cur[95:64]  ^ n0;
  assign n2   = cur[63:32]  ^ n1;
  assign n3   = cur[31:0]   ^ n2;

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = EXPAND;
        end
      end
      EXPAND: begin
        step = 1'b1;
        if (rnd == 4'(NR)) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rnd        <= 4'd0;
      rcon       <= 8'h01;
      cur        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      for (int i = 0; i <= NR; i++) key_buf[i] <= '0;
    end else begin
      state <= state_next;
      done  <= last;
      if (load) begin
        key_buf[0] <= bus.key_in;
        cur        <= bus.key_in;
        rnd        <= 4'd1;
        rcon       <= 8'h01;
        keys_valid <= 1'b0;
        busy       <= 1'b1;
      end
      if (step) begin
        key_buf[rnd] <= {n0, n1, n2, n3};
        cur          <= {n0, n1, n2, n3};
        rcon         <= xtime(rcon);
        rnd          <= rnd + 4'd1;
      end
      if (last) begin
        busy       <= 1'b0;
        keys_valid <= 1'b1;
      end
    end
  end

  assign bus.rd_key     = (bus.rd_idx <= 4'(NR)) ? key_buf[bus.rd_idx] : 128'h0;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.keys_valid = keys_valid;

endmodule

`default_nettype wire
